regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 64, data width of each register.
REQ-002 Parameter NREG, default 32, register count (power of two, >=4); AW = clog2(NREG) derived locally.
REQ-003 Parameter X0_ZERO, default 1, register 0 hardwired to zero when 1.
REQ-004 Parameter BYPASS, default 1, same-cycle write-to-read forwarding when 1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 we  in  1  writeback enable.
REQ-008 Rw  in  AW  writeback register index.
REQ-009 W  in  XLEN  writeback data.
REQ-010 Ra, Rb  in  AW each  read indices.
REQ-011 A, B  out  XLEN each  read data.
REQ-012 issue_en  in  1  producer issued, marks issue_rd pending.
REQ-013 issue_rd  in  AW  destination of issued producer.
REQ-014 flush  in  1  clear all pending marks.
REQ-015 busy_a, busy_b  out  1 each  Ra/Rb have an outstanding producer.
REQ-016 pend_cnt  out  AW+1  number of pending registers.
REQ-017 ready  out  1  init sweep complete; block accepts writes/issues.

Function
REQ-018 Two states, INIT and RUN; INIT zeroes register[cnt] each cycle, cnt 0..NREG-1, then RUN next cycle; INIT lasts exactly NREG cycles.
REQ-019 ready = 1 only in RUN; we, issue_en, flush ignored while ready = 0.
REQ-020 A/B combinational: 0 if ready = 0; 0 if X0_ZERO and index 0; W if BYPASS, we, ready, Rw equals index, and Rw non-zero-or-X0_ZERO=0; else stored register.
REQ-021 Write: register[Rw] <= W on edge when we and ready, suppressed for Rw = 0 when X0_ZERO = 1.
REQ-022 Scoreboard: pend bit per register; issue_en sets pend[issue_rd], we clears pend[Rw]; index 0 never set when X0_ZERO = 1.
REQ-023 Same-cycle issue_en and we to same index: set wins (new producer outstanding).
REQ-024 flush clears all pend bits; flush has priority over same-cycle issue_en; same-cycle we still writes data.
REQ-025 busy_a = pend[Ra] and not (BYPASS and we and Rw = Ra); busy_b likewise with Rb.
REQ-026 pend_cnt registered, equals popcount of pend after each edge; range 0..NREG (NREG-1 when X0_ZERO).
REQ-027 Repeated issue to an already-pending index leaves pend_cnt unchanged; we to non-pending index leaves it unchanged.

Reset
REQ-028 rst = 0 at an edge: state INIT, cnt 0, all pend 0, pend_cnt 0; ready = 0 from that edge; A/B = 0.
REQ-029 rst asserted mid-INIT or mid-RUN restarts full NREG-cycle sweep; no partial state survives.
REQ-030 Register contents valid only after sweep; no reset on data array other than sweep writes.

Structure
REQ-031 Shared package regfile_pkg holds default XLEN/NREG constants and INIT/RUN state encoding.
REQ-032 Sub-module regfile_scoreboard holds pend vector, set/clear/flush priority and pend_cnt; top holds array, sweep FSM, read muxes.

Verification
REQ-033 Reset 1 cycle, release -> ready = 0 for 32 cycles, 1 on 33rd; A = B = 0 throughout; any register read = 0 after.
REQ-034 Write x1 = 0x1111111111111111, x2 = 0x2222222222222222, x0 = all-ones; read Ra = 1, Rb = 2 -> A/B those values; Ra = Rb = 0 -> 0.
REQ-035 we Rw = 5, W = 0xABCD with Ra = 5 same cycle -> A = 0xABCD (BYPASS = 1); stored value prior when BYPASS = 0.
REQ-036 issue 3, 7, 7 -> pend_cnt = 2, busy on Ra = 7; we Rw = 7 -> busy_a 0 same cycle, pend_cnt = 1; issue 3 + we 3 same cycle -> pend[3] stays 1.
REQ-037 issue 4 with flush same cycle, pend_cnt 3 -> pend_cnt 0, busy all 0.
REQ-038 rst at cycle 10 of RUN with pend_cnt 2 -> pend_cnt 0, ready 0, full 32-cycle sweep, x1 reads 0 after.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and sweep-FSM encoding for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned NREG_DEF = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer tracking: one pend bit per register plus a registered popcount.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG    = NREG_DEF,
    parameter bit          X0_ZERO = 1'b1,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  rw,
    input  logic                     issue_en,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    input  logic                     flush,
    input  logic [$clog2(NREG)-1:0]  ra,
    input  logic [$clog2(NREG)-1:0]  rb,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [$clog2(NREG):0]    pend_cnt
);

    localparam int unsigned AW = $clog2(NREG);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [AW:0]     cnt_d;

    // Clear is applied before set so a same-cycle reissue keeps the register pending.
    always_comb begin
        pend_d = pend_q;
        if (en) begin
            if (flush) begin
                pend_d = '0;
            end else begin
                if (we) begin
                    pend_d[rw] = 1'b0;
                end
                if (issue_en && !(X0_ZERO && issue_rd == '0)) begin
                    pend_d[issue_rd] = 1'b1;
                end
            end
        end
        cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q   <= '0;
            pend_cnt <= '0;
        end else begin
            pend_q   <= pend_d;
            pend_cnt <= cnt_d;
        end
    end

    assign busy_a = pend_q[ra] && !(BYPASS && we && rw == ra);
    assign busy_b = pend_q[rb] && !(BYPASS && we && rw == rb);

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a zeroing init sweep and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NREG    = NREG_DEF,
    parameter bit          X0_ZERO = 1'b1,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  Rw,
    input  logic [XLEN-1:0]          W,
    input  logic [$clog2(NREG)-1:0]  Ra,
    input  logic [$clog2(NREG)-1:0]  Rb,
    output logic [XLEN-1:0]          A,
    output logic [XLEN-1:0]          B,
    input  logic                     issue_en,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    input  logic                     flush,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [$clog2(NREG):0]    pend_cnt,
    output logic                     ready
);

    localparam int unsigned AW = $clog2(NREG);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;
    logic [XLEN-1:0] mem [NREG];
    logic            we_run;
    logic            wr_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREG - 1)) begin
                state_d = RUN;
            end
        end
    end

    assign ready  = (state_q == RUN);
    assign we_run = ready && we;
    assign wr_en  = we_run && !(X0_ZERO && Rw == '0);

    // Data array has no reset of its own; the sweep is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == INIT) begin
                mem[cnt_q] <= '0;
            end else if (wr_en) begin
                mem[Rw] <= W;
            end
        end
    end

    always_comb begin
        A = '0;
        B = '0;
        if (ready && !(X0_ZERO && Ra == '0)) begin
            A = (BYPASS && wr_en && Rw == Ra) ? W : mem[Ra];
        end
        if (ready && !(X0_ZERO && Rb == '0)) begin
            B = (BYPASS && wr_en && Rw == Rb) ? W : mem[Rb];
        end
    end

    regfile_scoreboard #(
        .NREG    (NREG),
        .X0_ZERO (X0_ZERO),
        .BYPASS  (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .en       (ready),
        .we       (we_run),
        .rw       (Rw),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .ra       (Ra),
        .rb       (Rb),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: init sweep, read/write/bypass, scoreboard, reset restart.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  rw;
    logic [63:0] w;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [63:0] a, b, a_nb, b_nb;
    logic        busy_a, busy_b, busy_a_nb, busy_b_nb;
    logic [5:0]  pend_cnt, pend_cnt_nb;
    logic        ready, ready_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(64), .NREG(32), .X0_ZERO(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .we(we), .Rw(rw), .W(w), .Ra(ra), .Rb(rb), .A(a), .B(b),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
        .busy_a(busy_a), .busy_b(busy_b), .pend_cnt(pend_cnt), .ready(ready)
    );

    regfile_sb #(.XLEN(64), .NREG(32), .X0_ZERO(1'b1), .BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst), .we(we), .Rw(rw), .W(w), .Ra(ra), .Rb(rb), .A(a_nb), .B(b_nb),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
        .busy_a(busy_a_nb), .busy_b(busy_b_nb), .pend_cnt(pend_cnt_nb), .ready(ready_nb)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rw;
        logic [63:0] w;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ie;
        logic [4:0]  ird;
        logic        fl;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] ea_nb;
        logic        bsa;
        logic        bsb;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t expq[$];

    localparam logic [63:0] X1 = 64'h1111111111111111;
    localparam logic [63:0] X2 = 64'h2222222222222222;
    localparam logic [63:0] ONES = '1;

    function automatic vec_t mk(logic we_i, logic [4:0] rw_i, logic [63:0] w_i,
                                logic [4:0] ra_i, logic [4:0] rb_i, logic ie_i,
                                logic [4:0] ird_i, logic fl_i, logic [63:0] ea_i,
                                logic [63:0] eb_i, logic [63:0] eanb_i, logic bsa_i,
                                logic bsb_i, logic [5:0] cnt_i);
        vec_t v;
        v.we = we_i; v.rw = rw_i; v.w = w_i; v.ra = ra_i; v.rb = rb_i;
        v.ie = ie_i; v.ird = ird_i; v.fl = fl_i; v.ea = ea_i; v.eb = eb_i;
        v.ea_nb = eanb_i; v.bsa = bsa_i; v.bsb = bsb_i; v.cnt = cnt_i;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        we = 1'b0; rw = '0; w = '0; issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    // Full sweep after a reset release; write/issue/flush are driven to prove they are ignored.
    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; rw = 5'(i); w = ONES; ra = 5'd1; rb = 5'(i);
            issue_en = 1'b1; issue_rd = 5'(i); flush = 1'b0;
            #1;
            chk({tag, "_ready_low"}, 64'(ready), 64'd0);
            chk({tag, "_a_zero"}, a, 64'd0);
            @(posedge clk); #1;
        end
        idle();
        ra = '0; rb = '0;
        #1;
        chk({tag, "_ready_high"}, 64'(ready), 64'd1);
        chk({tag, "_cnt_after_sweep"}, 64'(pend_cnt), 64'd0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        we = v.we; rw = v.rw; w = v.w; ra = v.ra; rb = v.rb;
        issue_en = v.ie; issue_rd = v.ird; flush = v.fl;
        expq.push_back(v);
        @(negedge clk);
        e = expq.pop_front();
        chk($sformatf("v%0d_A", idx), a, e.ea);
        chk($sformatf("v%0d_B", idx), b, e.eb);
        chk($sformatf("v%0d_A_nobypass", idx), a_nb, e.ea_nb);
        chk($sformatf("v%0d_busy_a", idx), 64'(busy_a), 64'(e.bsa));
        chk($sformatf("v%0d_busy_b", idx), 64'(busy_b), 64'(e.bsb));
        @(posedge clk); #1;
        chk($sformatf("v%0d_pend_cnt", idx), 64'(pend_cnt), 64'(e.cnt));
    endtask

    initial begin
        idle();
        ra = '0; rb = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_cnt", 64'(pend_cnt), 64'd0);
        chk("reset_a", a, 64'd0);
        chk("reset_b", b, 64'd0);
        rst = 1'b1;
        sweep("init");

        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            #1;
            chk($sformatf("zero_x%0d", i), a, 64'd0);
            chk($sformatf("zero_nb_x%0d", 31 - i), b_nb, 64'd0);
        end

        //                we    rw  w                  ra  rb  ie  ird  fl  ea                 eb     ea_nb  bsa bsb cnt
        vecs.push_back(mk(1, 5'd1, X1,                 0,  0,  0,  0,  0,  0,                 0,     0,     0,  0,  0));
        vecs.push_back(mk(1, 5'd2, X2,                 1,  2,  0,  0,  0,  X1,                X2,    X1,    0,  0,  0));
        vecs.push_back(mk(1, 5'd0, ONES,               1,  2,  0,  0,  0,  X1,                X2,    X1,    0,  0,  0));
        vecs.push_back(mk(0, 5'd0, 0,                  0,  0,  0,  0,  0,  0,                 0,     0,     0,  0,  0));
        vecs.push_back(mk(1, 5'd0, ONES,               0,  0,  0,  0,  0,  0,                 0,     0,     0,  0,  0));
        vecs.push_back(mk(1, 5'd5, 64'hABCD,           5,  1,  0,  0,  0,  64'hABCD,          X1,    0,     0,  0,  0));
        vecs.push_back(mk(0, 5'd0, 0,                  5,  2,  0,  0,  0,  64'hABCD,          X2,    64'hABCD, 0, 0, 0));
        vecs.push_back(mk(0, 5'd0, 0,                  3,  7,  1,  3,  0,  0,                 0,     0,     0,  0,  1));
        vecs.push_back(mk(0, 5'd0, 0,                  3,  7,  1,  7,  0,  0,                 0,     0,     1,  0,  2));
        vecs.push_back(mk(0, 5'd0, 0,                  7,  3,  1,  7,  0,  0,                 0,     0,     1,  1,  2));
        vecs.push_back(mk(1, 5'd7, 64'h7777,           7,  3,  0,  0,  0,  64'h7777,          0,     0,     0,  1,  1));
        vecs.push_back(mk(1, 5'd9, 64'h9,              9,  3,  0,  0,  0,  64'h9,             0,     0,     0,  1,  1));
        vecs.push_back(mk(1, 5'd3, 64'h3333,           3,  7,  1,  3,  0,  64'h3333,          64'h7777, 0,  0,  0,  1));
        vecs.push_back(mk(0, 5'd0, 0,                  3,  3,  0,  0,  0,  64'h3333,          64'h3333, 64'h3333, 1, 1, 1));
        vecs.push_back(mk(0, 5'd0, 0,                  3,  0,  1, 10,  0,  64'h3333,          0,     64'h3333, 1, 0, 2));
        vecs.push_back(mk(0, 5'd0, 0,                 10, 11,  1, 11,  0,  0,                 0,     0,     1,  0,  3));
        vecs.push_back(mk(1, 5'd12, 64'hC,            10, 11,  1,  4,  1,  0,                 0,     0,     1,  1,  0));
        vecs.push_back(mk(0, 5'd0, 0,                  4, 12,  0,  0,  0,  0,                 64'hC, 0,     0,  0,  0));
        vecs.push_back(mk(0, 5'd0, 0,                  3, 11,  0,  0,  0,  64'h3333,          0,     64'h3333, 0, 0, 0));
        vecs.push_back(mk(0, 5'd0, 0,                  0,  0,  1,  0,  0,  0,                 0,     0,     0,  0,  0));
        vecs.push_back(mk(0, 5'd0, 0,                  0,  0,  0,  0,  0,  0,                 0,     0,     0,  0,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset during RUN with two producers outstanding must restart the whole sweep.
        idle();
        issue_en = 1'b1; issue_rd = 5'd20;
        @(posedge clk); #1;
        issue_rd = 5'd21;
        @(posedge clk); #1;
        idle();
        ra = 5'd1; rb = 5'd20;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_cnt", 64'(pend_cnt), 64'd2);
        chk("pre_rst_x1", a, X1);
        chk("pre_rst_busy_b", 64'(busy_b), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrun_rst_ready", 64'(ready), 64'd0);
        chk("midrun_rst_cnt", 64'(pend_cnt), 64'd0);
        chk("midrun_rst_a", a, 64'd0);
        rst = 1'b1;
        sweep("resweep");
        ra = 5'd1; rb = 5'd20;
        #1;
        chk("resweep_x1", a, 64'd0);
        chk("resweep_busy_b", 64'(busy_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
